addr_bus_sched: RTL and testbench

//  Sequencer/arbiter for the load/store address datapath. Each cycle it picks
//  one of store-buffer drain, cache miss (optional spill, then fill) or external

---
 rtl/addr_bus_sched.sv | 211 +++++++++++++++++++++
 tb/tb_addr_bus_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_bus_sched.sv
// Load/store address-bus sequencer: arbitrates probe, miss (spill/fill) and store-buffer drain.
// Optional bypass of the store buffer is enabled by defining ADDR_BUS_SCHED_FAST_STORE_EN.
module addr_bus_sched #(
    parameter int LINE_WORDS   = 8,
    parameter int PROBE_CYCLES = 1
) (
    input  logic       Phi1,
    input  logic       Reset_s1,
    input  logic       stoBufEmpty_s1,
    input  logic       storeReq_s1,
    input  logic       missReq_s1,
    input  logic       missDirty_s1,
    input  logic       missFromBuf_s1,
    input  logic       probeReq_s1,
    input  logic       extGrant_s1,
    input  logic       extWordAck_s1,
    output logic       extReq_s1,
    output logic       selStoreAddr_s1,
    output logic       selMissAddr_s1,
    output logic       selProbeAddr_s1,
    output logic       selSpillAddr_s1,
    output logic       selBuffMissAddr_s1,
    output logic       popStoreBuffer_s1,
    output logic       selFastStore_s1m,
    output logic       drvSharedMemAddr_q1,
    output logic       latchMissAddr_s2,
    output logic [4:0] lineOffset_s1,
    output logic [2:0] missOp_s1,
    output logic       missDone_s1,
    output logic       probeDone_s1
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int PCNT_BITS = (PROBE_CYCLES > 1) ? $clog2(PROBE_CYCLES) : 1;
    localparam logic [WORD_BITS-1:0] LAST_WORD  = WORD_BITS'(LINE_WORDS - 1);
    localparam logic [PCNT_BITS-1:0] LAST_PROBE = PCNT_BITS'(PROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        SPILL_REQ,
        SPILL,
        FILL_REQ,
        FILL,
        STORE
    } schedState;

    typedef struct packed {
        logic       extReq;
        logic       selStore;
        logic       selMiss;
        logic       selProbe;
        logic       selSpill;
        logic       selBuffMiss;
        logic       pop;
        logic       drv;
        logic       latchMiss;
        logic [4:0] lineOffset;
        logic       missDone;
        logic       probeDone;
    } schedOuts;

    schedState             stateReg, stateNext;
    logic [WORD_BITS-1:0]  wordCntReg, wordCntNext;
    logic [PCNT_BITS-1:0]  probeCntReg, probeCntNext;
    logic                  buffMissReg, buffMissNext;
    schedOuts              outsReg, outsNext;
    logic                  latchNext;
    logic                  missDoneNext;
    logic                  fastStoreNext;
    logic                  wordAdvance;
    logic                  missBusy;

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            stateReg    <= IDLE;
            wordCntReg  <= '0;
            probeCntReg <= '0;
            buffMissReg <= 1'b0;
            outsReg     <= '0;
        end else begin
            stateReg    <= stateNext;
            wordCntReg  <= wordCntNext;
            probeCntReg <= probeCntNext;
            buffMissReg <= buffMissNext;
            outsReg     <= outsNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        wordCntNext   = wordCntReg;
        probeCntNext  = probeCntReg;
        buffMissNext  = buffMissReg;
        latchNext     = 1'b0;
        missDoneNext  = 1'b0;
        fastStoreNext = 1'b0;
        // A word only counts while we own the bus; losing grant freezes the walk.
        wordAdvance   = extGrant_s1 & extWordAck_s1;

        case (stateReg)
            IDLE: begin
                // missReq is still high in the missDone cycle; do not restart that miss.
                if (probeReq_s1) begin
                    stateNext    = PROBE;
                    probeCntNext = '0;
                end else if (missReq_s1 && !outsReg.missDone) begin
                    stateNext    = missDirty_s1 ? SPILL_REQ : FILL_REQ;
                    buffMissNext = missFromBuf_s1;
                    latchNext    = !missFromBuf_s1;
                end else if (!stoBufEmpty_s1) begin
                    stateNext = STORE;
                end
`ifdef ADDR_BUS_SCHED_FAST_STORE_EN
                else if (storeReq_s1) begin
                    fastStoreNext = 1'b1;
                end
`endif
            end
            PROBE: begin
                if (probeCntReg == LAST_PROBE) begin
                    stateNext = IDLE;
                end else begin
                    probeCntNext = probeCntReg + 1'b1;
                end
            end
            SPILL_REQ, FILL_REQ: begin
                if (!missReq_s1) begin
                    stateNext = IDLE;
                end else if (extGrant_s1) begin
                    stateNext   = (stateReg == SPILL_REQ) ? SPILL : FILL;
                    wordCntNext = '0;
                end
            end
            SPILL, FILL: begin
                if (wordAdvance) begin
                    if (wordCntReg == LAST_WORD) begin
                        wordCntNext = '0;
                        if (stateReg == SPILL) begin
                            stateNext = FILL_REQ;
                        end else begin
                            stateNext    = IDLE;
                            missDoneNext = 1'b1;
                        end
                    end else begin
                        wordCntNext = wordCntReg + 1'b1;
                    end
                end
            end
            STORE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so they register alongside it.
        missBusy = (stateNext == SPILL_REQ) || (stateNext == SPILL) ||
                   (stateNext == FILL_REQ)  || (stateNext == FILL);

        outsNext             = '0;
        outsNext.extReq      = missBusy;
        outsNext.selMiss     = missBusy;
        outsNext.selBuffMiss = missBusy & buffMissNext;
        outsNext.selSpill    = (stateNext == SPILL);
        outsNext.drv         = (stateNext == SPILL) || (stateNext == FILL);
        outsNext.lineOffset  = outsNext.drv ? 5'({wordCntNext, 2'b00}) : 5'd0;
        outsNext.selStore    = (stateNext == STORE) | fastStoreNext;
        outsNext.pop         = (stateNext == STORE);
        outsNext.selProbe    = (stateNext == PROBE);
        outsNext.probeDone   = (stateNext == PROBE) && (probeCntNext == LAST_PROBE);
        outsNext.latchMiss   = latchNext;
        outsNext.missDone    = missDoneNext;
    end

`ifdef ADDR_BUS_SCHED_FAST_STORE_EN
    logic fastStoreReg;

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            fastStoreReg <= 1'b0;
        end else begin
            fastStoreReg <= fastStoreNext;
        end
    end

    assign selFastStore_s1m = fastStoreReg;
`else
    logic unusedFastStore;

    assign unusedFastStore  = fastStoreNext | storeReq_s1;
    assign selFastStore_s1m = 1'b0;
`endif

    assign extReq_s1           = outsReg.extReq;
    assign selStoreAddr_s1     = outsReg.selStore;
    assign selMissAddr_s1      = outsReg.selMiss;
    assign selProbeAddr_s1     = outsReg.selProbe;
    assign selSpillAddr_s1     = outsReg.selSpill;
    assign selBuffMissAddr_s1  = outsReg.selBuffMiss;
    assign popStoreBuffer_s1   = outsReg.pop;
    // Reset releases the shared bus in the same cycle rather than at the next edge.
    assign drvSharedMemAddr_q1 = outsReg.drv & ~Reset_s1;
    assign latchMissAddr_s2    = outsReg.latchMiss;
    assign lineOffset_s1       = outsReg.lineOffset;
    assign missOp_s1           = 3'b000;
    assign missDone_s1         = outsReg.missDone;
    assign probeDone_s1        = outsReg.probeDone;

endmodule

// File: tb/tb_addr_bus_sched.sv
// Scoreboard bench for addr_bus_sched: stimulus queues expected output snapshots,
// a monitor pops and compares one on every cycle with an output event or a marked check.
module tb_addr_bus_sched;

    logic       Phi1 = 1'b0;
    logic       Reset_s1, stoBufEmpty_s1, storeReq_s1, missReq_s1, missDirty_s1;
    logic       missFromBuf_s1, probeReq_s1, extGrant_s1, extWordAck_s1;
    logic       extReq_s1, selStoreAddr_s1, selMissAddr_s1, selProbeAddr_s1;
    logic       selSpillAddr_s1, selBuffMissAddr_s1, popStoreBuffer_s1, selFastStore_s1m;
    logic       drvSharedMemAddr_q1, latchMissAddr_s2, missDone_s1, probeDone_s1;
    logic [4:0] lineOffset_s1;
    logic [2:0] missOp_s1;

    addr_bus_sched dut (
        .Phi1                (Phi1),
        .Reset_s1            (Reset_s1),
        .stoBufEmpty_s1      (stoBufEmpty_s1),
        .storeReq_s1         (storeReq_s1),
        .missReq_s1          (missReq_s1),
        .missDirty_s1        (missDirty_s1),
        .missFromBuf_s1      (missFromBuf_s1),
        .probeReq_s1         (probeReq_s1),
        .extGrant_s1         (extGrant_s1),
        .extWordAck_s1       (extWordAck_s1),
        .extReq_s1           (extReq_s1),
        .selStoreAddr_s1     (selStoreAddr_s1),
        .selMissAddr_s1      (selMissAddr_s1),
        .selProbeAddr_s1     (selProbeAddr_s1),
        .selSpillAddr_s1     (selSpillAddr_s1),
        .selBuffMissAddr_s1  (selBuffMissAddr_s1),
        .popStoreBuffer_s1   (popStoreBuffer_s1),
        .selFastStore_s1m    (selFastStore_s1m),
        .drvSharedMemAddr_q1 (drvSharedMemAddr_q1),
        .latchMissAddr_s2    (latchMissAddr_s2),
        .lineOffset_s1       (lineOffset_s1),
        .missOp_s1           (missOp_s1),
        .missDone_s1         (missDone_s1),
        .probeDone_s1        (probeDone_s1)
    );

    always #5 Phi1 = ~Phi1;

    typedef struct packed {
        logic       extReq, selStore, selMiss, selProbe, selSpill, selBuff;
        logic       pop, fast, drv, latch;
        logic [4:0] off;
        logic [2:0] op;
        logic       missDone, probeDone;
    } outv_t;

    outv_t expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;
    logic  sampleReq = 1'b0;

    function automatic outv_t mk(input logic er, input logic ss, input logic sm, input logic sp,
                                 input logic sx, input logic sb, input logic po, input logic fa,
                                 input logic dr, input logic la, input logic [4:0] of,
                                 input logic md, input logic pd);
        outv_t v;
        v = '{extReq: er, selStore: ss, selMiss: sm, selProbe: sp, selSpill: sx, selBuff: sb,
              pop: po, fast: fa, drv: dr, latch: la, off: of, op: 3'b000,
              missDone: md, probeDone: pd};
        return v;
    endfunction

    function automatic outv_t eIdle();      return mk(0,0,0,0,0,0,0,0,0,0,5'd0,0,0); endfunction
    function automatic outv_t eStore();     return mk(0,1,0,0,0,0,1,0,0,0,5'd0,0,0); endfunction
    function automatic outv_t eFast();      return mk(0,1,0,0,0,0,0,1,0,0,5'd0,0,0); endfunction
    function automatic outv_t eProbe();     return mk(0,0,0,1,0,0,0,0,0,0,5'd0,0,1); endfunction
    function automatic outv_t eMissDone();  return mk(0,0,0,0,0,0,0,0,0,0,5'd0,1,0); endfunction
    function automatic outv_t eReq(input logic buff, input logic latch);
        return mk(1,0,1,0,0,buff,0,0,0,latch,5'd0,0,0);
    endfunction
    function automatic outv_t eWord(input logic spill, input logic buff, input logic [4:0] off,
                                    input logic drv);
        return mk(1,0,1,0,spill,buff,0,0,drv,0,off,0,0);
    endfunction

    function automatic outv_t actual();
        return '{extReq: extReq_s1, selStore: selStoreAddr_s1, selMiss: selMissAddr_s1,
                 selProbe: selProbeAddr_s1, selSpill: selSpillAddr_s1, selBuff: selBuffMissAddr_s1,
                 pop: popStoreBuffer_s1, fast: selFastStore_s1m, drv: drvSharedMemAddr_q1,
                 latch: latchMissAddr_s2, off: lineOffset_s1, op: missOp_s1,
                 missDone: missDone_s1, probeDone: probeDone_s1};
    endfunction

    task automatic expect_out(input string nm, input outv_t v);
        expQ.push_back(v);
        nameQ.push_back(nm);
    endtask

    task automatic step();
        @(posedge Phi1);
        #1;
    endtask

    // Forces the monitor to check this cycle even if no output event occurs.
    task automatic mark();
        sampleReq = 1'b1;
        @(negedge Phi1);
        #1;
        sampleReq = 1'b0;
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return probeDone_s1;
            1:       return latchMissAddr_s2;
            2:       return missDone_s1;
            3:       return popStoreBuffer_s1;
            4:       return drvSharedMemAddr_q1 && (lineOffset_s1 == 5'd12);
            5:       return drvSharedMemAddr_q1 && (lineOffset_s1 == 5'd20);
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitOut(input int w, input string nm);
        int n = 0;
        while (!cond(w) && n < 40) begin
            step();
            n++;
        end
        if (!cond(w)) begin
            checks++;
            failures++;
            $display("FAIL wait_%s got=timeout required=event_within_40_cycles", nm);
        end
    endtask

    // Monitor: one transaction per event cycle.
    initial begin
        outv_t a, e;
        string nm;
        forever begin
            @(negedge Phi1);
            a = actual();
            if (sampleReq || a.pop || a.fast || a.probeDone || a.missDone || a.latch ||
                (a.drv && extWordAck_s1 && extGrant_s1)) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%h required=no_event", a);
                end else begin
                    e  = expQ.pop_front();
                    nm = nameQ.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL %s got=%h required=%h", nm, a, e);
                    end else begin
                        $display("txn %s ok outputs=%h", nm, a);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_s1 = 1'b1; stoBufEmpty_s1 = 1'b1; storeReq_s1 = 1'b0; missReq_s1 = 1'b0;
        missDirty_s1 = 1'b0; missFromBuf_s1 = 1'b0; probeReq_s1 = 1'b0;
        extGrant_s1 = 1'b0; extWordAck_s1 = 1'b0;

        // Reset state
        step(); step();
        expect_out("reset_state", eIdle());
        mark();
        Reset_s1 = 1'b0;
        step();

        // Store-buffer drain: one-cycle pop then idle
        expect_out("store_pop", eStore());
        expect_out("store_after", eIdle());
        stoBufEmpty_s1 = 1'b0;
        step();
        stoBufEmpty_s1 = 1'b1;
        step();
        mark();

        // Direct store with empty buffer
`ifdef ADDR_BUS_SCHED_FAST_STORE_EN
        expect_out("fast_store", eFast());
`else
        expect_out("fast_store_off", eIdle());
`endif
        storeReq_s1 = 1'b1;
        step();
        storeReq_s1 = 1'b0;
        mark();

        // Miss withdrawn before grant: back to idle, no missDone
        expect_out("drop_req", eReq(1'b0, 1'b1));
        expect_out("drop_idle1", eIdle());
        expect_out("drop_idle2", eIdle());
        missReq_s1 = 1'b1;
        step();
        missReq_s1 = 1'b0;
        step(); mark();
        step(); mark();

        // Probe + miss + store together: probe, full clean fill, then drain
        expect_out("prio_probe", eProbe());
        expect_out("prio_fill_req", eReq(1'b0, 1'b1));
        for (int i = 0; i < 8; i++) expect_out($sformatf("fill_w%0d", i), eWord(1'b0, 1'b0, 5'(i * 4), 1'b1));
        expect_out("fill_done", eMissDone());
        expect_out("prio_store", eStore());
        expect_out("prio_idle", eIdle());
        probeReq_s1 = 1'b1; missReq_s1 = 1'b1; stoBufEmpty_s1 = 1'b0;
        step();
        waitOut(0, "probe_done");
        probeReq_s1 = 1'b0;
        step();
        waitOut(1, "latch");
        extGrant_s1 = 1'b1; extWordAck_s1 = 1'b1;
        waitOut(2, "miss_done");
        missReq_s1 = 1'b0; extGrant_s1 = 1'b0; extWordAck_s1 = 1'b0;
        waitOut(3, "pop");
        stoBufEmpty_s1 = 1'b1;
        step();
        mark();

        // Dirty miss from store buffer; grant lost at spill word 5; probe held off
        expect_out("spill_req", eReq(1'b1, 1'b0));
        for (int i = 0; i < 5; i++) expect_out($sformatf("spill_w%0d", i), eWord(1'b1, 1'b1, 5'(i * 4), 1'b1));
        for (int i = 0; i < 3; i++) expect_out($sformatf("spill_hold%0d", i), eWord(1'b1, 1'b1, 5'd20, 1'b1));
        for (int i = 5; i < 8; i++) expect_out($sformatf("spill_w%0d", i), eWord(1'b1, 1'b1, 5'(i * 4), 1'b1));
        expect_out("refill_req", eReq(1'b1, 1'b0));
        for (int i = 0; i < 8; i++) expect_out($sformatf("refill_w%0d", i), eWord(1'b0, 1'b1, 5'(i * 4), 1'b1));
        expect_out("refill_done", eMissDone());
        expect_out("late_probe", eProbe());
        expect_out("late_idle", eIdle());
        missReq_s1 = 1'b1; missDirty_s1 = 1'b1; missFromBuf_s1 = 1'b1;
        step();
        extGrant_s1 = 1'b1; extWordAck_s1 = 1'b1;
        mark();
        step();
        waitOut(5, "spill_w5");
        extGrant_s1 = 1'b0; extWordAck_s1 = 1'b0; probeReq_s1 = 1'b1;
        mark(); step();
        mark(); step();
        mark(); step();
        extGrant_s1 = 1'b1; extWordAck_s1 = 1'b1;
        step(); step(); step();
        mark();
        waitOut(2, "refill_done");
        missReq_s1 = 1'b0; missDirty_s1 = 1'b0; missFromBuf_s1 = 1'b0;
        extGrant_s1 = 1'b0; extWordAck_s1 = 1'b0;
        waitOut(0, "late_probe");
        probeReq_s1 = 1'b0;
        step();
        mark();

        // Reset during fill word 3: bus released at once, idle next cycle
        expect_out("abort_req", eReq(1'b0, 1'b1));
        for (int i = 0; i < 3; i++) expect_out($sformatf("abort_w%0d", i), eWord(1'b0, 1'b0, 5'(i * 4), 1'b1));
        expect_out("abort_w3_rst", eWord(1'b0, 1'b0, 5'd12, 1'b0));
        expect_out("abort_idle", eIdle());
        expect_out("final_idle", eIdle());
        missReq_s1 = 1'b1; extGrant_s1 = 1'b1; extWordAck_s1 = 1'b1;
        step();
        waitOut(4, "fill_w3");
        Reset_s1 = 1'b1; extGrant_s1 = 1'b0; extWordAck_s1 = 1'b0;
        mark();
        step();
        mark();
        Reset_s1 = 1'b0; missReq_s1 = 1'b0;
        step(); step();
        mark();
        step(); step();

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained got=%0d_pending required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
